// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over a req/ack byte port,
// stalling the pipeline until the access completes; other ops pass through.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_EXMEM_i,
    input  logic        wreg_EXMEM_i,
    input  logic [4:0]  waddr_EXMEM_i,
    input  logic [31:0] alurslt_EXMEM_i,
    input  logic [31:0] storedata_EXMEM_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        wreg_MEMWB_o,
    output logic [4:0]  waddr_MEMWB_o,
    output logic [31:0] wdata_MEMWB_o,
    output logic        rq_STALLER_o
);

    localparam logic [7:0]  ALU_LB_OP    = 8'h10;
    localparam logic [7:0]  ALU_LH_OP    = 8'h11;
    localparam logic [7:0]  ALU_LW_OP    = 8'h12;
    localparam logic [7:0]  ALU_LBU_OP   = 8'h13;
    localparam logic [7:0]  ALU_LHU_OP   = 8'h14;
    localparam logic [7:0]  ALU_SB_OP    = 8'h18;
    localparam logic [7:0]  ALU_SH_OP    = 8'h19;
    localparam logic [7:0]  ALU_SW_OP    = 8'h1A;
    localparam logic        DISABLE      = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic [31:0] buf_r;
    logic        mem_op_s;
    logic        store_s;
    logic [1:0]  last_s;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            ALU_LB_OP, ALU_LH_OP, ALU_LW_OP, ALU_LBU_OP, ALU_LHU_OP,
            ALU_SB_OP, ALU_SH_OP, ALU_SW_OP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            ALU_SB_OP, ALU_SH_OP, ALU_SW_OP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Index of the final byte lane, i.e. byte count minus one
    function automatic logic [1:0] last_idx(input logic [7:0] op);
        case (op)
            ALU_LH_OP, ALU_LHU_OP, ALU_SH_OP: return 2'd1;
            ALU_LW_OP, ALU_SW_OP:             return 2'd3;
            default:                          return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_result(input logic [7:0] op, input logic [31:0] b);
        case (op)
            ALU_LB_OP:  return {{24{b[7]}}, b[7:0]};
            ALU_LBU_OP: return {24'h00_0000, b[7:0]};
            ALU_LH_OP:  return {{16{b[15]}}, b[15:0]};
            ALU_LHU_OP: return {16'h0000, b[15:0]};
            ALU_LW_OP:  return b;
            default:    return ZERO_WORD;
        endcase
    endfunction

    assign mem_op_s = is_mem_op(aluop_EXMEM_i);
    assign store_s  = is_store(aluop_EXMEM_i);
    assign last_s   = last_idx(aluop_EXMEM_i);

    // Access sequencer: byte counter and load assembly buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
            buf_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= 2'd0;
                    if (mem_op_s) begin
                        state_r <= ACCESS;
                        buf_r   <= 32'h0000_0000;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (mem_ack_i) begin
                        if (!store_s) begin
                            buf_r[{cnt_r, 3'b000} +: 8] <= mem_rdata_i;
                        end
                        if (cnt_r == last_s) begin
                            state_r <= DONE;
                        end else begin
                            cnt_r <= cnt_r + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    cnt_r   <= 2'd0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

    // Memory port and write-back outputs decoded from the current state
    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = 32'h0000_0000;
        mem_wdata_o   = 8'h00;
        wreg_MEMWB_o  = wreg_EXMEM_i;
        waddr_MEMWB_o = waddr_EXMEM_i;
        wdata_MEMWB_o = alurslt_EXMEM_i;
        rq_STALLER_o  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    wreg_MEMWB_o  = DISABLE;
                    waddr_MEMWB_o = NOP_REG_ADDR;
                    wdata_MEMWB_o = ZERO_WORD;
                    rq_STALLER_o  = 1'b1;
                end else begin
                    rq_STALLER_o  = 1'b0;
                end
            end
            ACCESS: begin
                mem_req_o     = 1'b1;
                mem_we_o      = store_s;
                mem_addr_o    = alurslt_EXMEM_i + {30'd0, cnt_r};
                mem_wdata_o   = storedata_EXMEM_i[{cnt_r, 3'b000} +: 8];
                wreg_MEMWB_o  = DISABLE;
                waddr_MEMWB_o = NOP_REG_ADDR;
                wdata_MEMWB_o = ZERO_WORD;
                rq_STALLER_o  = 1'b1;
            end
            DONE: begin
                wdata_MEMWB_o = load_result(aluop_EXMEM_i, buf_r);
            end
            default: begin
                rq_STALLER_o  = 1'b0;
            end
        endcase
        // Reset must release the pipeline at once, even with a memory op still present
        if (rst) begin
            rq_STALLER_o = 1'b0;
        end else begin
            rq_STALLER_o = rq_STALLER_o;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores with wait states,
// address wrap and asynchronous reset in the middle of an access.
module tb_mem_stage;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_LB  = 8'h10;
    localparam logic [7:0] OP_LW  = 8'h12;
    localparam logic [7:0] OP_LBU = 8'h13;
    localparam logic [7:0] OP_LHU = 8'h14;
    localparam logic [7:0] OP_SH  = 8'h19;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] alurslt;
    logic [31:0] storedata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        wreg_out;
    logic [4:0]  waddr_out;
    logic [31:0] wdata_out;
    logic        stall;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0]  ack_delay = 2'd0;
    logic [1:0]  wcnt      = 2'd0;
    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .aluop_EXMEM_i     (aluop),
        .wreg_EXMEM_i      (wreg),
        .waddr_EXMEM_i     (waddr),
        .alurslt_EXMEM_i   (alurslt),
        .storedata_EXMEM_i (storedata),
        .mem_req_o         (mem_req),
        .mem_we_o          (mem_we),
        .mem_addr_o        (mem_addr),
        .mem_wdata_o       (mem_wdata),
        .mem_rdata_i       (mem_rdata),
        .mem_ack_i         (mem_ack),
        .wreg_MEMWB_o      (wreg_out),
        .waddr_MEMWB_o     (waddr_out),
        .wdata_MEMWB_o     (wdata_out),
        .rq_STALLER_o      (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'hEF;
            32'h0000_0101: return 8'hBE;
            32'h0000_0102: return 8'hAD;
            32'h0000_0103: return 8'hDE;
            32'h0000_0201: return 8'h80;
            32'hFFFF_FFFF: return 8'h34;
            32'h0000_0000: return 8'h92;
            default:       return 8'h00;
        endcase
    endfunction

    assign mem_rdata = model_rd(mem_addr);
    assign mem_ack   = mem_req && (wcnt == ack_delay);

    always @(posedge clk) begin
        wcnt <= (mem_req && !mem_ack) ? wcnt + 2'd1 : 2'd0;
        if (mem_req && mem_we && mem_ack) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] op, input logic w, input logic [4:0] wa,
                          input logic [31:0] r, input logic [31:0] sd);
        aluop = op; wreg = w; waddr = wa; alurslt = r; storedata = sd;
    endtask

    initial begin
        rst = 1'b1;
        set_op(OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0);
        #2;
        check("rst_req",   {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, stall},   32'd0);
        check("rst_addr",  mem_addr,         32'h0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // ADD pass-through, same cycle
        @(negedge clk);
        set_op(OP_ADD, 1'b1, 5'd5, 32'h1234_5678, 32'h0); #1;
        check("add_wreg",  {31'd0, wreg_out}, 32'd1);
        check("add_waddr", {27'd0, waddr_out}, 32'd5);
        check("add_wdata", wdata_out, 32'h1234_5678);
        check("add_stall", {31'd0, stall}, 32'd0);
        check("add_req",   {31'd0, mem_req}, 32'd0);

        // LW at 0x100, ack tied high
        @(negedge clk);
        ack_delay = 2'd0;
        set_op(OP_LW, 1'b1, 5'd7, 32'h0000_0100, 32'h0); #1;
        check("lw_idle_stall", {31'd0, stall}, 32'd1);
        check("lw_idle_wreg",  {31'd0, wreg_out}, 32'd0);
        check("lw_idle_req",   {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("lw_req",   {31'd0, mem_req}, 32'd1);
            check("lw_addr",  mem_addr, 32'h0000_0100 + 32'(i));
            check("lw_we",    {31'd0, mem_we}, 32'd0);
            check("lw_stall", {31'd0, stall}, 32'd1);
        end
        @(negedge clk); #1;
        check("lw_done_stall", {31'd0, stall}, 32'd0);
        check("lw_done_req",   {31'd0, mem_req}, 32'd0);
        check("lw_done_wreg",  {31'd0, wreg_out}, 32'd1);
        check("lw_done_waddr", {27'd0, waddr_out}, 32'd7);
        check("lw_done_wdata", wdata_out, 32'hDEAD_BEEF);

        // LB then LBU back-to-back at 0x201
        @(negedge clk);
        set_op(OP_LB, 1'b1, 5'd3, 32'h0000_0201, 32'h0); #1;
        check("lb_idle_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        check("lb_addr",  mem_addr, 32'h0000_0201);
        check("lb_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        check("lb_done_stall", {31'd0, stall}, 32'd0);
        check("lb_done_wdata", wdata_out, 32'hFFFF_FF80);
        set_op(OP_LBU, 1'b1, 5'd4, 32'h0000_0201, 32'h0);
        @(negedge clk); #1;
        check("lbu_idle_stall", {31'd0, stall}, 32'd1);
        check("lbu_idle_req",   {31'd0, mem_req}, 32'd0);
        @(negedge clk); #1;
        check("lbu_addr", mem_addr, 32'h0000_0201);
        @(negedge clk); #1;
        check("lbu_done_stall", {31'd0, stall}, 32'd0);
        check("lbu_done_waddr", {27'd0, waddr_out}, 32'd4);
        check("lbu_done_wdata", wdata_out, 32'h0000_0080);

        // SH at 0x3FF with two wait cycles per byte
        @(negedge clk);
        ack_delay = 2'd2;
        wr_addr.delete(); wr_data.delete();
        set_op(OP_SH, 1'b0, 5'd0, 32'h0000_03FF, 32'hAABB_CCDD); #1;
        check("sh_idle_stall", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("sh_b0_addr",  mem_addr, 32'h0000_03FF);
            check("sh_b0_data",  {24'd0, mem_wdata}, 32'h0000_00DD);
            check("sh_b0_we",    {31'd0, mem_we}, 32'd1);
            check("sh_b0_stall", {31'd0, stall}, 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("sh_b1_addr", mem_addr, 32'h0000_0400);
            check("sh_b1_data", {24'd0, mem_wdata}, 32'h0000_00CC);
        end
        @(negedge clk); #1;
        check("sh_done_stall", {31'd0, stall}, 32'd0);
        check("sh_done_wreg",  {31'd0, wreg_out}, 32'd0);
        check("sh_done_wdata", wdata_out, 32'h0);
        check("sh_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("sh_wr0_addr", wr_addr[0], 32'h0000_03FF);
            check("sh_wr0_data", {24'd0, wr_data[0]}, 32'h0000_00DD);
            check("sh_wr1_addr", wr_addr[1], 32'h0000_0400);
            check("sh_wr1_data", {24'd0, wr_data[1]}, 32'h0000_00CC);
        end

        // LHU wrapping from 0xFFFFFFFF to 0x00000000
        @(negedge clk);
        ack_delay = 2'd0;
        set_op(OP_LHU, 1'b1, 5'd9, 32'hFFFF_FFFF, 32'h0); #1;
        check("lhu_idle_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        check("lhu_addr0", mem_addr, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        check("lhu_addr1", mem_addr, 32'h0000_0000);
        @(negedge clk); #1;
        check("lhu_done_wdata", wdata_out, 32'h0000_9234);

        // Asynchronous reset after the first byte of an LW
        @(negedge clk);
        set_op(OP_LW, 1'b1, 5'd7, 32'h0000_0100, 32'h0); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rlw_addr_before", mem_addr, 32'h0000_0101);
        #2 rst = 1'b1; #1;
        check("rlw_req",   {31'd0, mem_req}, 32'd0);
        check("rlw_stall", {31'd0, stall}, 32'd0);
        check("rlw_wreg",  {31'd0, wreg_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_op(OP_ADD, 1'b1, 5'd9, 32'h0000_0055, 32'h0); #1;
        check("post_rst_stall", {31'd0, stall}, 32'd0);
        check("post_rst_wdata", wdata_out, 32'h0000_0055);
        @(negedge clk);
        set_op(OP_LB, 1'b1, 5'd3, 32'h0000_0201, 32'h0); #1;
        @(negedge clk); #1;
        check("post_rst_lb_addr", mem_addr, 32'h0000_0201);
        @(negedge clk); #1;
        check("post_rst_lb_wdata", wdata_out, 32'hFFFF_FF80);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, sitting between the EX/MEM and MEM/WB registers. It consumes the operation, address/result and store data that the execute stage emits. It performs loads and stores byte-by-byte over a req/ack byte-wide memory port, holding the pipeline through `rq_STALLER_o` until the access completes. Non-memory operations pass straight through to write-back.

## Interface
- No parameters. Opcode encodings, `AluOpBus`, `Enable`/`Disable`, `ZeroWord` and `NopRegAddr` come from macro.vh.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset (`Enable` = 1)
- `aluop_EXMEM_i`  in  `AluOpBus`  operation code from EX
- `wreg_EXMEM_i`  in  1  register write enable
- `waddr_EXMEM_i`  in  5  destination register
- `alurslt_EXMEM_i`  in  32  ALU result; effective address for load/store ops
- `storedata_EXMEM_i`  in  32  store data (rs2 value)
- `mem_req_o`  out  1  byte access request
- `mem_we_o`  out  1  1 = write byte, 0 = read byte
- `mem_addr_o`  out  32  byte address
- `mem_wdata_o`  out  8  write byte
- `mem_rdata_i`  in  8  read byte, valid when `mem_ack_i` = 1
- `mem_ack_i`  in  1  current byte accepted / read data valid
- `wreg_MEMWB_o`  out  1  write enable to MEM/WB
- `waddr_MEMWB_o`  out  5  destination register to MEM/WB
- `wdata_MEMWB_o`  out  32  write-back data
- `rq_STALLER_o`  out  1  stall request (freezes IF..EX/MEM, bubbles MEM/WB)

## Operation
- Memory op set: ALU_LB/LH/LW/LBU/LHU_OP (loads) and ALU_SB/SH/SW_OP (stores). Byte count N is 1 for B/BU, 2 for H/HU, 4 for W.
- FSM states:
  - IDLE to ACCESS on the edge where a memory op is present. Byte counter `cnt` := 0.
  - ACCESS to DONE on the edge where `mem_ack_i` = 1 and `cnt` = N-1.
  - ACCESS stays in ACCESS on any other ack (`cnt`++) or on no ack (hold).
  - DONE to IDLE unconditionally.
- Non-memory op in IDLE is combinational pass-through:
  - `wreg_MEMWB_o`=`wreg_EXMEM_i`, `waddr_MEMWB_o`=`waddr_EXMEM_i`, `wdata_MEMWB_o`=`alurslt_EXMEM_i`, `rq_STALLER_o`=0.
- ACCESS drives the memory port:
  - `mem_req_o`=1, `mem_addr_o`=`alurslt_EXMEM_i`+`cnt` (32-bit wrap), `mem_we_o`=1 for stores.
  - `mem_wdata_o`=`storedata_EXMEM_i[8*cnt+7:8*cnt]` (little-endian).
- Loads capture `mem_rdata_i` into byte lane `cnt` of an internal 32-bit buffer on each ack edge.
- Alignment is not required; any address is accessed byte-wise.
- DONE outputs:
  - `wreg_MEMWB_o`=`wreg_EXMEM_i`, `waddr_MEMWB_o`=`waddr_EXMEM_i`.
  - `wdata_MEMWB_o`: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW takes the full buffer; stores give `ZeroWord`.
- `rq_STALLER_o` = (IDLE and memory op present) or ACCESS. It is 0 in DONE so the pipeline advances on the DONE edge.
- IDLE-with-memop and ACCESS outputs: `wreg_MEMWB_o`=`Disable`, `waddr_MEMWB_o`=`NopRegAddr`, `wdata_MEMWB_o`=`ZeroWord` (bubble).
- EX/MEM inputs are held stable by the stall. The block re-reads them every cycle and does not latch op or address.

## Timing
- Reset (asynchronous, any state): FSM to IDLE, `cnt`=0, buffer=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0. The pass-through outputs show the reset-state inputs.
- Reset mid-ACCESS: partial bytes are discarded, `mem_req_o` drops immediately, and no write-back occurs.
- Handshake:
  - Address, we and wdata stay stable while `mem_req_o`=1 and `mem_ack_i`=0.
  - `mem_req_o` may stay high back-to-back across bytes; the address advances the cycle after each ack.
  - `mem_ack_i` is ignored outside ACCESS.
- With `mem_ack_i` tied high, an N-byte op occupies MEM for N+2 cycles, with `rq_STALLER_o` high for N+1 cycles. LW: 6 cycles / stall 5. LB: 3 / stall 2.
- Each wait cycle (ack=0) adds one cycle.
- A memory op immediately following another is recognised in the IDLE cycle right after DONE. No extra bubble is inserted.

## Test plan
- ADD pass-through: aluop=ADD, wreg=1, waddr=5, alurslt=0x12345678 -> same cycle `wreg_MEMWB_o`=1, waddr=5, wdata=0x12345678, `rq_STALLER_o`=0, `mem_req_o`=0.
- LW, ack tied high: address 0x100, memory bytes 0xEF,0xBE,0xAD,0xDE -> addresses 0x100..0x103 on consecutive cycles; stall high 5 cycles; DONE wdata=0xDEADBEEF, wreg=1.
- LB/LBU at 0x201 holding 0x80 -> LB wdata=0xFFFFFF80; LBU wdata=0x00000080; stall 2 cycles each.
- SH: storedata=0xAABBCCDD, address 0x3FF, ack delayed 2 cycles per byte -> writes 0xDD@0x3FF then 0xCC@0x400; address/data held through waits; DONE wreg=0; no writes of 0xBB/0xAA.
- LHU at 0xFFFFFFFF -> second byte address wraps to 0x00000000; result zero-extended.
- Reset asserted after byte 1 of LW -> `mem_req_o` and `rq_STALLER_o` drop without waiting for a clock edge; state IDLE; no write-back.
